regfile_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined core; successor to the single-write, dual-read integer regfile.
- Adds configurable width, depth and read-port count, and a second write port.
- Adds an optional hardwired-zero register and optional write-to-read bypass.
- Adds a per-register busy scoreboard so decode can detect pending writebacks.

---
 rtl/regfile_mp.sv | 98 +++++++++
 tb/tb_regfile_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NREAD combinational read ports,
// optional hardwired zero register, optional write-to-read bypass and a busy scoreboard.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [XLEN-1:0]       wd1,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  bset_en,
    input  logic [AW-1:0]         bset_ad,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wv0, wv1, bv;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !(ZERO_REG != 0 && a == '0);
    endfunction

    // Write qualifiers include reset so bypass is suppressed while reset is low.
    assign wv0 = we0 & reset & addr_ok(wa0);
    assign wv1 = we1 & reset & addr_ok(wa1);
    assign bv  = bset_en & addr_ok(bset_ad);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < NREGS; n++) regs[n] <= '0;
            busy <= '0;
        end else begin
            for (int n = 0; n < NREGS; n++) begin
                if (wv1 && wa1 == AW'(n))
                    regs[n] <= wd1;
                else if (wv0 && wa0 == AW'(n))
                    regs[n] <= wd0;
                // A new producer issued this edge outranks the retiring write.
                if (bv && bset_ad == AW'(n))
                    busy[n] <= 1'b1;
                else if ((wv0 && wa0 == AW'(n)) || (wv1 && wa1 == AW'(n)))
                    busy[n] <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] val;
        logic            bsy;
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            a   = ra[i*AW +: AW];
            val = '0;
            bsy = 1'b0;
            for (int n = 0; n < NREGS; n++) begin
                if (a == AW'(n)) begin
                    val = regs[n];
                    bsy = busy[n];
                end
            end
            if (BYPASS != 0) begin
                if (wv1 && wa1 == a) begin
                    val = wd1;
                    bsy = 1'b0;
                end else if (wv0 && wa0 == a) begin
                    val = wd0;
                    bsy = 1'b0;
                end
            end
            if (!addr_ok(a)) begin
                val = '0;
                bsy = 1'b0;
            end
            rd[i*XLEN +: XLEN] = val;
            rbusy[i]           = bsy;
        end
    end

    always_comb begin
        busy_vec = busy;
        if (ZERO_REG != 0) busy_vec[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (BYPASS=0) and a 64-bit/16-reg/4-port
// bypass instance share stimulus and are compared against an array-based model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, bset_en;
    logic [4:0]  wa0, wa1, bset_ad;
    logic [63:0] wd0, wd1;
    logic [4:0]  rp [4];

    logic [9:0]   ra_a;
    logic [63:0]  rd_a;
    logic [1:0]   rbusy_a;
    logic [31:0]  bvec_a;
    logic [19:0]  ra_b;
    logic [255:0] rd_b;
    logic [3:0]   rbusy_b;
    logic [15:0]  bvec_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_a [32];
    logic [63:0] m_b [16];
    bit          b_a [32];
    bit          b_b [16];

    always #5 clk = ~clk;

    assign ra_a = {rp[1], rp[0]};
    assign ra_b = {rp[3], rp[2], rp[1], rp[0]};

    regfile_mp dut_a (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0[31:0]),
        .we1(we1), .wa1(wa1), .wd1(wd1[31:0]),
        .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
        .bset_en(bset_en), .bset_ad(bset_ad), .busy_vec(bvec_a)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .AW(5), .NREAD(4), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
        .bset_en(bset_en), .bset_ad(bset_ad), .busy_vec(bvec_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ok(input int a, input int nregs);
        return a < nregs && a != 0;
    endfunction

    // Instance A: plain array read, no forwarding.
    function automatic logic [31:0] exp_rd_a(input int a);
        return ok(a, 32) ? m_a[a] : 32'h0;
    endfunction

    function automatic bit exp_bz_a(input int a);
        return ok(a, 32) ? b_a[a] : 1'b0;
    endfunction

    // Instance B: port 1 write, then port 0 write, then stored value.
    function automatic logic [63:0] exp_rd_b(input int a);
        if (!ok(a, 16)) return 64'h0;
        if (reset && we1 && int'(wa1) == a) return wd1;
        if (reset && we0 && int'(wa0) == a) return wd0;
        return m_b[a];
    endfunction

    function automatic bit exp_bz_b(input int a);
        if (!ok(a, 16)) return 1'b0;
        if (reset && ((we1 && int'(wa1) == a) || (we0 && int'(wa0) == a))) return 1'b0;
        return b_b[a];
    endfunction

    task automatic check_all();
        logic [31:0] va;
        logic [15:0] vb;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("a_rd%0d@%0d", i, rp[i]), {32'h0, rd_a[i*32 +: 32]}, {32'h0, exp_rd_a(int'(rp[i]))});
            chk($sformatf("a_rbusy%0d@%0d", i, rp[i]), {63'h0, rbusy_a[i]}, {63'h0, exp_bz_a(int'(rp[i]))});
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b_rd%0d@%0d", i, rp[i]), rd_b[i*64 +: 64], exp_rd_b(int'(rp[i])));
            chk($sformatf("b_rbusy%0d@%0d", i, rp[i]), {63'h0, rbusy_b[i]}, {63'h0, exp_bz_b(int'(rp[i]))});
        end
        for (int n = 0; n < 32; n++) va[n] = b_a[n];
        for (int n = 0; n < 16; n++) vb[n] = b_b[n];
        chk("a_busy_vec", {32'h0, bvec_a}, {32'h0, va});
        chk("b_busy_vec", {48'h0, bvec_b}, {48'h0, vb});
    endtask

    task automatic update_model();
        if (!reset) begin
            for (int n = 0; n < 32; n++) begin m_a[n] = '0; b_a[n] = 0; end
            for (int n = 0; n < 16; n++) begin m_b[n] = '0; b_b[n] = 0; end
            return;
        end
        if (we0 && ok(int'(wa0), 32)) begin m_a[wa0] = wd0[31:0]; b_a[wa0] = 0; end
        if (we1 && ok(int'(wa1), 32)) begin m_a[wa1] = wd1[31:0]; b_a[wa1] = 0; end
        if (bset_en && ok(int'(bset_ad), 32)) b_a[bset_ad] = 1;
        if (we0 && ok(int'(wa0), 16)) begin m_b[wa0] = wd0; b_b[wa0] = 0; end
        if (we1 && ok(int'(wa1), 16)) begin m_b[wa1] = wd1; b_b[wa1] = 0; end
        if (bset_en && ok(int'(bset_ad), 16)) b_b[bset_ad] = 1;
    endtask

    // Inputs are driven 1 ns after a rising edge; checks run at the falling edge.
    task automatic tick();
        #4;
        check_all();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; bset_en = 0;
        wa0 = 0; wa1 = 0; bset_ad = 0; wd0 = 0; wd1 = 0;
    endtask

    initial begin
        reset = 0;
        idle();
        for (int i = 0; i < 4; i++) rp[i] = 0;
        @(posedge clk);
        #1;
        update_model();
        reset = 1;

        // Fill regs 1..31, then reset with a concurrent write to reg 5.
        for (int r = 1; r < 32; r++) begin
            we0 = 1; wa0 = 5'(r); wd0 = 64'hDEADBEEF_DEADBEEF;
            rp[0] = 5'(r); rp[1] = 5'(r - 1);
            tick();
        end
        idle();
        rp[0] = 5; rp[1] = 31; rp[2] = 5; rp[3] = 15;
        tick();
        reset = 0; we0 = 1; wa0 = 5; wd0 = 64'h1111_2222_3333_4444;
        tick();
        reset = 1; idle();
        #4;
        chk("rst_rd5", {32'h0, rd_a[31:0]}, 64'h0);
        chk("rst_rd31", {32'h0, rd_a[63:32]}, 64'h0);
        chk("rst_bvec", {32'h0, bvec_a}, 64'h0);
        @(posedge clk); #1;

        // Write reg 9 on instance A: invisible until after the edge.
        we0 = 1; wa0 = 9; wd0 = 64'h0000_0000_AFAE2E03; rp[0] = 9; rp[1] = 15;
        #4;
        chk("wr9_pre", {32'h0, rd_a[31:0]}, 64'h0);
        tick();
        idle();
        #4;
        chk("wr9_post", {32'h0, rd_a[31:0]}, 64'hAFAE2E03);
        chk("rd15_zero", {32'h0, rd_a[63:32]}, 64'h0);
        @(posedge clk); #1;

        // Bypass on instance B, then a same-address collision.
        we1 = 1; wa1 = 12; wd1 = 64'hFF34A018; rp[0] = 12;
        #4;
        chk("byp_wd1", rd_b[63:0], 64'hFF34A018);
        we0 = 1; wa0 = 12; wd0 = 64'h1010AAEF;
        tick();
        idle();
        #4;
        chk("coll_p1_wins", rd_b[63:0], 64'hFF34A018);
        @(posedge clk); #1;

        // Zero register ignores writes and busy sets.
        we0 = 1; wa0 = 0; wd0 = 64'h12345678; bset_en = 1; bset_ad = 0; rp[0] = 0;
        tick();
        idle();
        tick();
        chk("zero_rd", {32'h0, rd_a[31:0]}, 64'h0);
        chk("zero_busy", {63'h0, bvec_a[0]}, 64'h0);

        // Scoreboard: set, set+write (set wins), write only (clears).
        rp[0] = 7; rp[1] = 7;
        bset_en = 1; bset_ad = 7;
        tick();
        chk("sb_set", {63'h0, bvec_a[7]}, 64'h1);
        chk("sb_rbusy", {63'h0, rbusy_a[0]}, 64'h1);
        we1 = 1; wa1 = 7; wd1 = 64'h77;
        tick();
        chk("sb_set_wins", {63'h0, bvec_a[7]}, 64'h1);
        bset_en = 0;
        tick();
        idle();
        #4;
        chk("sb_clear", {63'h0, bvec_a[7]}, 64'h0);
        @(posedge clk); #1;

        // 64-bit sweep instance: reg 15 on all ports, address 20 ignored.
        we0 = 1; wa0 = 15; wd0 = 64'h0123456789ABCDEF;
        tick();
        we0 = 1; wa0 = 20; wd0 = 64'hCAFE;
        for (int i = 0; i < 4; i++) rp[i] = 15;
        tick();
        idle();
        for (int i = 0; i < 4; i++) rp[i] = (i == 3) ? 5'd20 : 5'd15;
        #4;
        for (int i = 0; i < 3; i++) chk($sformatf("sweep_rd%0d", i), rd_b[i*64 +: 64], 64'h0123456789ABCDEF);
        chk("sweep_ra20", rd_b[255:192], 64'h0);
        @(posedge clk); #1;

        // Randomised traffic with occasional mid-run resets.
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 39) != 0);
            we0     = 1'($urandom_range(0, 1));
            we1     = 1'($urandom_range(0, 1));
            bset_en = 1'($urandom_range(0, 1));
            wa0     = 5'($urandom_range(0, 31));
            wa1     = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            bset_ad = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom_range(0, 31));
            wd0     = {$urandom, $urandom};
            wd1     = {$urandom, $urandom};
            for (int i = 0; i < 4; i++)
                rp[i] = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
            tick();
        end
        reset = 1; idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
